// File: rtl/reaction_game_ctrl.sv
// Reaction-time game controller: two players, ROUNDS trials each, averaged.
// Optional early-press foul detection is enabled with `define FOUL_DETECT_EN.
module reaction_game_ctrl #(
    parameter int ROUNDS       = 4,
    parameter int MIN_WAIT_MS  = 1000,
    parameter int WAIT_STEP_MS = 100,
    parameter int HOLD_MS      = 2000,
    parameter int MAX_TIME     = 999
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       tick_1ms,
    input  logic       btn_start,
    input  logic       btn_react,
    input  logic [3:0] rand_val,
    output logic [2:0] machine_state,
    output logic       cur_player,
    output logic [9:0] react_time,
    output logic [9:0] avr_react_time_A,
    output logic [9:0] avr_react_time_B,
    output logic       led_go,
    output logic       foul
);

    localparam int LOG2R = $clog2(ROUNDS);
    localparam int SUMW  = 10 + LOG2R;
    localparam int RW    = LOG2R + 1;
    localparam int WMAX  = MIN_WAIT_MS + 15 * WAIT_STEP_MS;
    localparam int CMAX  = (WMAX > HOLD_MS) ? WMAX : HOLD_MS;
    localparam int CNTW  = $clog2(CMAX + 1);

    localparam logic [CNTW-1:0] HOLD_LAST = CNTW'(HOLD_MS - 1);
    localparam logic [9:0]      MAX_T     = 10'(MAX_TIME);
    localparam logic [RW-1:0]   ROUNDS_C  = RW'(ROUNDS);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT     = 3'd1,
        CLR_CNT1 = 3'd2,
        START    = 3'd3,
        STORAGE  = 3'd4,
        CLR_CNT2 = 3'd5,
        AVERAGE  = 3'd6,
        COMPARE  = 3'd7
    } state_t;

    state_t          state_q, state_d;
    logic            cur_q, cur_d;
    logic [9:0]      react_q, react_d;
    logic [9:0]      avg_a_q, avg_a_d;
    logic [9:0]      avg_b_q, avg_b_d;
    logic [SUMW-1:0] sum_a_q, sum_a_d;
    logic [SUMW-1:0] sum_b_q, sum_b_d;
    logic [RW-1:0]   round_q, round_d;
    logic [CNTW-1:0] ms_q, ms_d;
    logic [3:0]      rand_q, rand_d;
    logic            led_q, led_d;
    logic            foul_q, foul_d;
    logic [CNTW-1:0] wait_last;

    assign wait_last = CNTW'(MIN_WAIT_MS)
                     + CNTW'(rand_q) * CNTW'(WAIT_STEP_MS)
                     - CNTW'(1);

    // State and datapath registers; reset discards every accumulated result.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cur_q   <= 1'b1;
            react_q <= '0;
            avg_a_q <= '0;
            avg_b_q <= '0;
            sum_a_q <= '0;
            sum_b_q <= '0;
            round_q <= '0;
            ms_q    <= '0;
            rand_q  <= '0;
            led_q   <= 1'b0;
            foul_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            react_q <= react_d;
            avg_a_q <= avg_a_d;
            avg_b_q <= avg_b_d;
            sum_a_q <= sum_a_d;
            sum_b_q <= sum_b_d;
            round_q <= round_d;
            ms_q    <= ms_d;
            rand_q  <= rand_d;
            led_q   <= led_d;
            foul_q  <= foul_d;
        end
    end

    // Next-state and next-datapath decode for the game sequence.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        react_d = react_q;
        avg_a_d = avg_a_q;
        avg_b_d = avg_b_q;
        sum_a_d = sum_a_q;
        sum_b_d = sum_b_q;
        round_d = round_q;
        ms_d    = ms_q;
        rand_d  = rand_q;
        foul_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (btn_start) begin
                    state_d = WAIT;
                    cur_d   = 1'b1;
                    round_d = '0;
                    sum_a_d = '0;
                    sum_b_d = '0;
                    avg_a_d = '0;
                    avg_b_d = '0;
                    react_d = '0;
                    ms_d    = '0;
                    rand_d  = rand_val;
                end
            end
            WAIT: begin
`ifdef FOUL_DETECT_EN
                if (btn_react) begin
                    foul_d = 1'b1;
                    rand_d = rand_val;
                    ms_d   = '0;
                end else if (tick_1ms) begin
                    if (ms_q == wait_last) begin
                        ms_d    = '0;
                        state_d = CLR_CNT1;
                    end else begin
                        ms_d = ms_q + CNTW'(1);
                    end
                end
`else
                if (tick_1ms) begin
                    if (ms_q == wait_last) begin
                        ms_d    = '0;
                        state_d = CLR_CNT1;
                    end else begin
                        ms_d = ms_q + CNTW'(1);
                    end
                end
`endif
            end
            CLR_CNT1: begin
                react_d = '0;
                ms_d    = '0;
                state_d = START;
            end
            START: begin
                if (btn_react || react_q == MAX_T) begin
                    state_d = STORAGE;
                    ms_d    = '0;
                    round_d = round_q + RW'(1);
                    if (cur_q) begin
                        sum_a_d = sum_a_q + SUMW'(react_q);
                    end else begin
                        sum_b_d = sum_b_q + SUMW'(react_q);
                    end
                end else if (tick_1ms) begin
                    react_d = react_q + 10'd1;
                end
            end
            STORAGE: begin
                if (tick_1ms) begin
                    if (ms_q == HOLD_LAST) begin
                        ms_d = '0;
                        if (round_q == ROUNDS_C) begin
                            state_d = AVERAGE;
                            if (cur_q) begin
                                avg_a_d = sum_a_q[SUMW-1:LOG2R];
                            end else begin
                                avg_b_d = sum_b_q[SUMW-1:LOG2R];
                            end
                        end else begin
                            state_d = CLR_CNT2;
                        end
                    end else begin
                        ms_d = ms_q + CNTW'(1);
                    end
                end
            end
            CLR_CNT2: begin
                ms_d    = '0;
                react_d = '0;
                rand_d  = rand_val;
                state_d = WAIT;
            end
            AVERAGE: begin
                if (tick_1ms) begin
                    if (ms_q == HOLD_LAST) begin
                        ms_d = '0;
                        if (cur_q) begin
                            cur_d   = 1'b0;
                            round_d = '0;
                            state_d = CLR_CNT2;
                        end else begin
                            state_d = COMPARE;
                        end
                    end else begin
                        ms_d = ms_q + CNTW'(1);
                    end
                end
            end
            COMPARE: begin
                if (btn_start) begin
                    state_d = IDLE;
                    cur_d   = 1'b1;
                    round_d = '0;
                    sum_a_d = '0;
                    sum_b_d = '0;
                    avg_a_d = '0;
                    avg_b_d = '0;
                    react_d = '0;
                    ms_d    = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        led_d = (state_d == START);
    end

    assign machine_state    = state_q;
    assign cur_player       = cur_q;
    assign react_time       = react_q;
    assign avr_react_time_A = avg_a_q;
    assign avr_react_time_B = avg_b_q;
    assign led_go           = led_q;
    assign foul             = foul_q;

endmodule

// File: tb/tb_reaction_game_ctrl.sv
// Directed bench for reaction_game_ctrl with short timing parameters.
// Expected values are hand-computed from the game rules.
module tb_reaction_game_ctrl;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       tick_1ms = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_react = 1'b0;
    logic [3:0] rand_val = 4'd3;
    logic [2:0] machine_state;
    logic       cur_player;
    logic [9:0] react_time;
    logic [9:0] avr_react_time_A;
    logic [9:0] avr_react_time_B;
    logic       led_go;
    logic       foul;

    int n_tests = 0;
    int n_fail  = 0;

    reaction_game_ctrl #(
        .ROUNDS(4),
        .MIN_WAIT_MS(10),
        .WAIT_STEP_MS(2),
        .HOLD_MS(5),
        .MAX_TIME(999)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .tick_1ms(tick_1ms),
        .btn_start(btn_start),
        .btn_react(btn_react),
        .rand_val(rand_val),
        .machine_state(machine_state),
        .cur_player(cur_player),
        .react_time(react_time),
        .avr_react_time_A(avr_react_time_A),
        .avr_react_time_B(avr_react_time_B),
        .led_go(led_go),
        .foul(foul)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            tick_1ms = 1'b1;
            cyc();
            tick_1ms = 1'b0;
        end
    endtask

    task automatic press();
        btn_react = 1'b1;
        cyc();
        btn_react = 1'b0;
    endtask

    task automatic start();
        btn_start = 1'b1;
        cyc();
        btn_start = 1'b0;
    endtask

    // From WAIT with rand latched as 3 (16 ms wait), pre ms already elapsed.
    task automatic trial(input int t, input int pre, input string tg);
        ticks(16 - pre);
        check({tg, "_clr1"}, machine_state, 2);
        cyc();
        check({tg, "_start"}, machine_state, 3);
        check({tg, "_led"}, led_go, 1);
        ticks(t);
        press();
        check({tg, "_stor"}, machine_state, 4);
        check({tg, "_rt"}, react_time, t);
        ticks(5);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", machine_state, 0);
        check("rst_cur", cur_player, 1);
        check("rst_rt", react_time, 0);
        check("rst_avgA", avr_react_time_A, 0);
        check("rst_avgB", avr_react_time_B, 0);
        check("rst_led", led_go, 0);
        check("rst_foul", foul, 0);
        rstn = 1'b1;
        cyc();

        // Wait length from latched rand, then reset in START.
        rand_val = 4'd3;
        start();
        check("a_wait", machine_state, 1);
        check("a_cur", cur_player, 1);
        rand_val = 4'd9;
        ticks(15);
        check("a_wait15", machine_state, 1);
        ticks(1);
        check("a_clr1", machine_state, 2);
        cyc();
        check("a_start", machine_state, 3);
        check("a_led", led_go, 1);
        ticks(123);
        check("a_rt123", react_time, 123);
        rstn = 1'b0;
        #1;
        check("mr_state", machine_state, 0);
        check("mr_rt", react_time, 0);
        check("mr_led", led_go, 0);
        check("mr_cur", cur_player, 1);
        check("mr_foul", foul, 0);
        rstn = 1'b1;
        rand_val = 4'd3;
        cyc();
        press();
        check("mr_react_ign", machine_state, 0);
        check("mr_react_foul", foul, 0);
        check("mr_react_led", led_go, 0);

        // Press and tick together; start ignored during STORAGE.
        start();
        ticks(16);
        cyc();
        check("b_led", led_go, 1);
        ticks(250);
        check("b_rt250", react_time, 250);
        btn_react = 1'b1;
        tick_1ms  = 1'b1;
        cyc();
        btn_react = 1'b0;
        tick_1ms  = 1'b0;
        check("b_stor", machine_state, 4);
        check("b_rt_hold", react_time, 250);
        check("b_led_off", led_go, 0);
        start();
        check("b_start_ign", machine_state, 4);
        ticks(4);
        check("b_hold4", machine_state, 4);
        check("b_rt4", react_time, 250);
        ticks(1);
        check("b_clr2", machine_state, 5);
        cyc();
        check("b_wait", machine_state, 1);
        check("b_rt0", react_time, 0);
        rstn = 1'b0;
        cyc();
        rstn = 1'b1;
        cyc();

        // Full game: A 100,200,300,401 -> 250; B 4x500 -> 500.
        start();
        trial(100, 0, "a1");
        check("a1_clr2", machine_state, 5);
        cyc();
        trial(200, 0, "a2");
        cyc();
        trial(300, 0, "a3");
        cyc();
        trial(401, 0, "a4");
        check("a_avg_st", machine_state, 6);
        check("a_avg", avr_react_time_A, 250);
        check("a_avg_cur", cur_player, 1);
        ticks(4);
        check("a_avg_hold", machine_state, 6);
        ticks(1);
        check("a_to_clr2", machine_state, 5);
        check("b_cur", cur_player, 0);
        cyc();
        check("b1_wait", machine_state, 1);
        ticks(5);
        press();
`ifdef FOUL_DETECT_EN
        check("foul_pulse", foul, 1);
        check("foul_wait", machine_state, 1);
        cyc();
        check("foul_clear", foul, 0);
        trial(500, 0, "b1");
`else
        check("nofoul", foul, 0);
        check("nofoul_wait", machine_state, 1);
        trial(500, 5, "b1");
`endif
        check("b1_clr2", machine_state, 5);
        cyc();
        trial(500, 0, "b2");
        cyc();
        trial(500, 0, "b3");
        cyc();
        trial(500, 0, "b4");
        check("b_avg_st", machine_state, 6);
        check("b_avg", avr_react_time_B, 500);
        ticks(5);
        check("cmp_st", machine_state, 7);
        check("cmp_cur", cur_player, 0);
        check("cmp_avgA", avr_react_time_A, 250);
        check("cmp_avgB", avr_react_time_B, 500);
        start();
        check("cmp_idle", machine_state, 0);
        check("cmp_clrA", avr_react_time_A, 0);
        check("cmp_clrB", avr_react_time_B, 0);
        check("cmp_cur1", cur_player, 1);

        // Saturation: no press, time caps at 999 and is recorded.
        start();
        ticks(16);
        cyc();
        ticks(999);
        check("sat_rt", react_time, 999);
        check("sat_st", machine_state, 3);
        ticks(1);
        check("sat_stor", machine_state, 4);
        check("sat_rt_hold", react_time, 999);
        ticks(5);
        check("sat_clr2", machine_state, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reaction_game_ctrl.md
REACTION_GAME_CTRL -- requirements
Module: reaction_game_ctrl

Interface
REQ-001 Parameter ROUNDS, default 4, trials per player; power of two, 2..16.
REQ-002 Parameter MIN_WAIT_MS, default 1000, fixed part of the pre-go delay in ms.
REQ-003 Parameter WAIT_STEP_MS, default 100, ms added per unit of the latched random value.
REQ-004 Parameter HOLD_MS, default 2000, display hold time in STORAGE and AVERAGE, in ms.
REQ-005 Parameter MAX_TIME, default 999, reaction-time saturation value in ms.
REQ-006 clk  input  1  system clock.
REQ-007 rstn  input  1  reset, asynchronous, active-low.
REQ-008 tick_1ms  input  1  one-clk strobe, once per ms.
REQ-009 btn_start  input  1  debounced one-clk pulse, start/restart.
REQ-010 btn_react  input  1  debounced one-clk pulse, player reaction.
REQ-011 rand_val  input  4  free-running pseudo-random value.
REQ-012 machine_state  output  3  IDLE=0, WAIT=1, CLR_CNT1=2, START=3, STORAGE=4, CLR_CNT2=5, AVERAGE=6, COMPARE=7.
REQ-013 cur_player  output  1  1=player A, 0=player B.
REQ-014 react_time  output  10  current trial time in ms.
REQ-015 avr_react_time_A, avr_react_time_B  output  10 each  per-player averages.
REQ-016 led_go  output  1  high exactly while machine_state==START.
REQ-017 foul  output  1  one-clk pulse on early press (see REQ-033).

Function
REQ-018 All outputs registered; state changes take effect the clk after the triggering input.
REQ-019 IDLE: on btn_start -> WAIT; cur_player=1, round count=0, both sums=0, both averages=0, react_time=0.
REQ-020 Entering WAIT latches rand_val; WAIT lasts MIN_WAIT_MS + latched*WAIT_STEP_MS tick_1ms strobes, then -> CLR_CNT1.
REQ-021 CLR_CNT1: exactly one clk; react_time=0, ms counter=0; -> START.
REQ-022 START: react_time +1 per tick_1ms; btn_react -> STORAGE.
REQ-023 START, btn_react and tick_1ms same clk: press wins, react_time not incremented.
REQ-024 START, react_time reaching MAX_TIME: saturates; next clk -> STORAGE with MAX_TIME recorded.
REQ-025 STORAGE first clk: react_time added to cur_player's sum (width 10+log2(ROUNDS), no overflow), round count +1; react_time held.
REQ-026 STORAGE held HOLD_MS strobes; then round count==ROUNDS -> AVERAGE, else -> CLR_CNT2.
REQ-027 CLR_CNT2: exactly one clk; ms counter=0, react_time=0; -> WAIT.
REQ-028 AVERAGE first clk: cur_player's average = sum >> log2(ROUNDS) (truncating); held HOLD_MS strobes.
REQ-029 AVERAGE exit: cur_player==1 -> cur_player=0, round count=0, -> CLR_CNT2; cur_player==0 -> COMPARE.
REQ-030 COMPARE: holds both averages; btn_start -> IDLE with REQ-019 clearing.
REQ-031 btn_start ignored in WAIT..AVERAGE; btn_react ignored outside START (except REQ-033).
REQ-032 Counters wrap never; ms counter width sized for largest of wait/hold.

Reset
REQ-034 rstn low, any state: state=IDLE, cur_player=1, react_time=0, both averages=0, sums=0, counters=0, latched rand=0, led_go=0, foul=0.
REQ-035 Reset mid-trial discards all accumulated results; release resumes in IDLE without spurious foul/led_go.

Configuration
REQ-033 Macro FOUL_DETECT_EN defined: btn_react in WAIT pulses foul one clk, relatches rand_val and restarts the WAIT count from 0; undefined: press in WAIT ignored, foul tied 0.

Verification (ROUNDS=4, MIN_WAIT_MS=10, WAIT_STEP_MS=2, HOLD_MS=5, MAX_TIME=999)
REQ-036 btn_start, rand_val=3 -> WAIT for 16 ticks, CLR_CNT1 one clk, START with led_go=1.
REQ-037 Press after 250 ticks in START -> STORAGE, react_time=250 held 5 ticks, then CLR_CNT2.
REQ-038 Player A times 100,200,300,401 -> avr_react_time_A=250, cur_player->0; B times 4x500 -> avr_react_time_B=500, COMPARE.
REQ-039 No press in START -> react_time saturates at 999, STORAGE records 999.
REQ-040 Press at tick 5 of WAIT: with FOUL_DETECT_EN foul pulse and WAIT restarts (16 more ticks); without, WAIT ends at tick 16.
REQ-041 rstn low during START with react_time=123 -> all outputs reset values, state IDLE, btn_react ignored until btn_start.
